// File: rtl/softex_tcdm_arbiter.sv
// softex_tcdm_arbiter
// Merges NB_CH streamer channels onto a single TCDM initiator port and routes
// read responses back to the channel that issued them, in issue order.
// Each handshake pushes {channel id, read bit} into an outstanding FIFO; each
// tcdm_r_valid_i pops it. Write responses are swallowed.
//
// Ports:
//   clk_i, rst_ni, clear_i       clock, async active-low reset, sync clear (idle only)
//   ch_req_i/ch_gnt_o            per-channel request / grant
//   ch_add_i/ch_wen_i/ch_be_i/ch_data_i   per-channel request fields (wen: 1 = read)
//   ch_r_valid_o/ch_r_data_o     per-channel read valid, broadcast read data
//   tcdm_*                       single TCDM initiator port
//   busy_o                       outstanding FIFO non-empty
//   err_o                        sticky: response arrived with nothing outstanding
//
// Optional feature macro: SOFTEX_ARB_STALL_CNT_EN adds stall_cnt_o, one 16-bit
// saturating counter per channel counting cycles with req=1 and gnt=0.
module softex_tcdm_arbiter #(
  parameter int NB_CH     = 4,
  parameter int DW        = 288,
  parameter int AW        = 32,
  parameter int MAX_OUTST = 4,
  parameter int ARB_MODE  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [NB_CH-1:0]      ch_req_i,
  output logic [NB_CH-1:0]      ch_gnt_o,
  input  logic [NB_CH*AW-1:0]   ch_add_i,
  input  logic [NB_CH-1:0]      ch_wen_i,
  input  logic [NB_CH*DW/8-1:0] ch_be_i,
  input  logic [NB_CH*DW-1:0]   ch_data_i,
  output logic [NB_CH-1:0]      ch_r_valid_o,
  output logic [DW-1:0]         ch_r_data_o,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [AW-1:0]         tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [DW/8-1:0]       tcdm_be_o,
  output logic [DW-1:0]         tcdm_data_o,
  input  logic                  tcdm_r_valid_i,
  input  logic [DW-1:0]         tcdm_r_data_i,
  output logic                  busy_o,
`ifdef SOFTEX_ARB_STALL_CNT_EN
  output logic [NB_CH*16-1:0]   stall_cnt_o,
`endif
  output logic                  err_o
);

  localparam int ID_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;
  localparam int BW    = DW / 8;
  localparam logic [NB_CH-1:0] ONE_HOT0 = {{(NB_CH-1){1'b0}}, 1'b1};

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [ID_W-1:0]  fifo_id_q  [MAX_OUTST];
  logic [ID_W-1:0]  fifo_id_d  [MAX_OUTST];
  logic             fifo_rd_q  [MAX_OUTST];
  logic             fifo_rd_d  [MAX_OUTST];

  logic             full_s, any_elig_s, hs_s, pop_s, win_found_s;
  logic [NB_CH-1:0] elig_s;
  logic [ID_W-1:0]  win_id_s, idx_s;
  logic [ID_W:0]    sum_s;

  // Eligibility and winner selection. A full FIFO masks every request, even
  // when a pop happens in the same cycle; reset masks them too so every
  // output is quiet while rst_ni is low.
  always_comb begin
    full_s      = (cnt_q == CNT_W'(MAX_OUTST));
    elig_s      = (full_s || !rst_ni) ? {NB_CH{1'b0}} : ch_req_i;
    any_elig_s  = |elig_s;
    win_id_s    = {ID_W{1'b0}};
    win_found_s = 1'b0;
    sum_s       = {(ID_W+1){1'b0}};
    idx_s       = {ID_W{1'b0}};
    for (int i = 0; i < NB_CH; i++) begin
      if (ARB_MODE == 1) begin
        idx_s = ID_W'(i);
      end else begin
        // Scan starts at the round-robin pointer and wraps modulo NB_CH.
        sum_s = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
        if (sum_s >= (ID_W+1)'(NB_CH)) begin
          sum_s = sum_s - (ID_W+1)'(NB_CH);
        end else begin
          sum_s = sum_s;
        end
        idx_s = sum_s[ID_W-1:0];
      end
      if (!win_found_s && elig_s[idx_s]) begin
        win_found_s = 1'b1;
        win_id_s    = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Zero-latency forwarding of the winner's request and grant steering.
  always_comb begin
    tcdm_req_o = any_elig_s;
    hs_s       = any_elig_s & tcdm_gnt_i;
    if (any_elig_s) begin
      tcdm_add_o  = ch_add_i[win_id_s*AW +: AW];
      tcdm_wen_o  = ch_wen_i[win_id_s];
      tcdm_be_o   = ch_be_i[win_id_s*BW +: BW];
      tcdm_data_o = ch_data_i[win_id_s*DW +: DW];
    end else begin
      tcdm_add_o  = {AW{1'b0}};
      tcdm_wen_o  = 1'b0;
      tcdm_be_o   = {BW{1'b0}};
      tcdm_data_o = {DW{1'b0}};
    end
    if (hs_s) begin
      ch_gnt_o = ONE_HOT0 << win_id_s;
    end else begin
      ch_gnt_o = {NB_CH{1'b0}};
    end
  end

  // Response routing: pop on every r_valid that has an owner; only reads
  // raise the owning channel's r_valid.
  always_comb begin
    pop_s       = tcdm_r_valid_i & (cnt_q != {CNT_W{1'b0}});
    ch_r_data_o = tcdm_r_data_i;
    if (pop_s && fifo_rd_q[rd_ptr_q]) begin
      ch_r_valid_o = ONE_HOT0 << fifo_id_q[rd_ptr_q];
    end else begin
      ch_r_valid_o = {NB_CH{1'b0}};
    end
    busy_o = (cnt_q != {CNT_W{1'b0}});
    err_o  = err_q;
  end

  // Next-state logic for pointers, occupancy, FIFO contents and error flag.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    fifo_id_d = fifo_id_q;
    fifo_rd_d = fifo_rd_q;
    if (clear_i) begin
      rr_ptr_d = {ID_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
      err_d    = 1'b0;
    end else begin
      if (hs_s) begin
        fifo_id_d[wr_ptr_q] = win_id_s;
        fifo_rd_d[wr_ptr_q] = tcdm_wen_o;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        if (ARB_MODE == 0) begin
          rr_ptr_d = (win_id_s == ID_W'(NB_CH-1)) ? {ID_W{1'b0}} : win_id_s + ID_W'(1);
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({hs_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      err_d = err_q | (tcdm_r_valid_i & ~busy_o);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= {ID_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        fifo_id_q[i] <= {ID_W{1'b0}};
        fifo_rd_q[i] <= 1'b0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      fifo_id_q <= fifo_id_d;
      fifo_rd_q <= fifo_rd_d;
    end
  end

`ifdef SOFTEX_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q [NB_CH];
  logic [15:0] stall_cnt_d [NB_CH];

  // Per-channel saturating stall counters.
  always_comb begin
    for (int i = 0; i < NB_CH; i++) begin
      if (clear_i) begin
        stall_cnt_d[i] = 16'h0000;
      end else if (ch_req_i[i] && !ch_gnt_o[i] && (stall_cnt_q[i] != 16'hFFFF)) begin
        stall_cnt_d[i] = stall_cnt_q[i] + 16'h0001;
      end else begin
        stall_cnt_d[i] = stall_cnt_q[i];
      end
      stall_cnt_o[i*16 +: 16] = stall_cnt_q[i];
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_CH; i++) begin
        stall_cnt_q[i] <= 16'h0000;
      end
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_softex_tcdm_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants / read responses into
// queues, negedge monitors pop and compare whenever the DUT presents them.
module tb_softex_tcdm_arbiter;
  localparam int NB_CH = 4;
  localparam int DW    = 288;
  localparam int AW    = 32;
  localparam int BW    = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_ni, clear_i, tcdm_gnt_i, tcdm_r_valid_i;
  logic [NB_CH-1:0]      ch_req_i, ch_wen_i;
  logic [NB_CH*AW-1:0]   ch_add_i;
  logic [NB_CH*BW-1:0]   ch_be_i;
  logic [NB_CH*DW-1:0]   ch_data_i;
  logic [DW-1:0]         tcdm_r_data_i;

  logic [NB_CH-1:0] rr_gnt, rr_rv, fp_gnt, fp_rv;
  logic [DW-1:0]    rr_rdata, fp_rdata, rr_wdata, fp_wdata;
  logic             rr_req, fp_req, rr_wen, fp_wen, rr_busy, fp_busy, rr_err, fp_err;
  logic [AW-1:0]    rr_add, fp_add;
  logic [BW-1:0]    rr_be, fp_be;

  softex_tcdm_arbiter #(.NB_CH(NB_CH), .DW(DW), .AW(AW), .MAX_OUTST(4), .ARB_MODE(0)) u_rr (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .ch_req_i(ch_req_i), .ch_gnt_o(rr_gnt), .ch_add_i(ch_add_i), .ch_wen_i(ch_wen_i),
    .ch_be_i(ch_be_i), .ch_data_i(ch_data_i), .ch_r_valid_o(rr_rv), .ch_r_data_o(rr_rdata),
    .tcdm_req_o(rr_req), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(rr_add), .tcdm_wen_o(rr_wen),
    .tcdm_be_o(rr_be), .tcdm_data_o(rr_wdata), .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_r_data_i(tcdm_r_data_i), .busy_o(rr_busy), .err_o(rr_err));

  softex_tcdm_arbiter #(.NB_CH(NB_CH), .DW(DW), .AW(AW), .MAX_OUTST(4), .ARB_MODE(1)) u_fp (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .ch_req_i(ch_req_i), .ch_gnt_o(fp_gnt), .ch_add_i(ch_add_i), .ch_wen_i(ch_wen_i),
    .ch_be_i(ch_be_i), .ch_data_i(ch_data_i), .ch_r_valid_o(fp_rv), .ch_r_data_o(fp_rdata),
    .tcdm_req_o(fp_req), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(fp_add), .tcdm_wen_o(fp_wen),
    .tcdm_be_o(fp_be), .tcdm_data_o(fp_wdata), .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_r_data_i(tcdm_r_data_i), .busy_o(fp_busy), .err_o(fp_err));

  int checks = 0;
  int errors = 0;
  logic mon_rr_en = 1'b0;
  logic mon_fp_en = 1'b0;

  logic [NB_CH-1:0] exp_gnt_q[$];
  logic [AW-1:0]    exp_add_q[$];
  logic [NB_CH-1:0] exp_rv_q[$];
  logic [DW-1:0]    exp_rd_q[$];
  logic [NB_CH-1:0] exp_fgnt_q[$];
  logic [AW-1:0]    exp_fadd_q[$];

  function automatic logic [AW-1:0] addr_of(input int ch);
    return 32'h1000_0000 + 32'(ch * 16);
  endfunction

  function automatic logic [DW-1:0] rdata_of(input int k);
    return {9{32'hD000_0000 + 32'(k)}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input int ch);
    exp_gnt_q.push_back(4'b0001 << ch);
    exp_add_q.push_back(addr_of(ch));
  endtask

  task automatic exp_rv(input int ch, input logic [DW-1:0] d);
    exp_rv_q.push_back(4'b0001 << ch);
    exp_rd_q.push_back(d);
  endtask

  // Round-robin instance monitor: grants and read responses.
  always @(negedge clk) begin
    if (mon_rr_en && rr_gnt != 4'b0000) begin
      checks++;
      if (exp_gnt_q.size() == 0) begin
        errors++;
        $display("FAIL rr_gnt_unexpected actual=%b expected=none", rr_gnt);
      end else begin
        logic [NB_CH-1:0] eg;
        logic [AW-1:0]    ea;
        eg = exp_gnt_q.pop_front();
        ea = exp_add_q.pop_front();
        if (rr_gnt !== eg || rr_add !== ea) begin
          errors++;
          $display("FAIL rr_gnt actual=%b/%h expected=%b/%h", rr_gnt, rr_add, eg, ea);
        end
      end
    end
    if (mon_rr_en && rr_rv != 4'b0000) begin
      checks++;
      if (exp_rv_q.size() == 0) begin
        errors++;
        $display("FAIL rr_rvalid_unexpected actual=%b expected=none", rr_rv);
      end else begin
        logic [NB_CH-1:0] ev;
        logic [DW-1:0]    ed;
        ev = exp_rv_q.pop_front();
        ed = exp_rd_q.pop_front();
        if (rr_rv !== ev || rr_rdata !== ed) begin
          errors++;
          $display("FAIL rr_rvalid actual=%b/%h expected=%b/%h", rr_rv, rr_rdata[31:0], ev, ed[31:0]);
        end
      end
    end
  end

  // Fixed-priority instance monitor: grants only.
  always @(negedge clk) begin
    if (mon_fp_en && fp_gnt != 4'b0000) begin
      checks++;
      if (exp_fgnt_q.size() == 0) begin
        errors++;
        $display("FAIL fp_gnt_unexpected actual=%b expected=none", fp_gnt);
      end else begin
        logic [NB_CH-1:0] eg;
        logic [AW-1:0]    ea;
        eg = exp_fgnt_q.pop_front();
        ea = exp_fadd_q.pop_front();
        if (fp_gnt !== eg || fp_add !== ea) begin
          errors++;
          $display("FAIL fp_gnt actual=%b/%h expected=%b/%h", fp_gnt, fp_add, eg, ea);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0;
    ch_req_i = 4'b1111; ch_wen_i = 4'b1111; tcdm_r_data_i = '0;
    ch_be_i = '1;
    for (int i = 0; i < NB_CH; i++) begin
      ch_add_i[i*AW +: AW]  = addr_of(i);
      ch_data_i[i*DW +: DW] = {9{32'hC0DE_0000 + 32'(i)}};
    end
    #2;
    // Reset state with requests held: everything quiet.
    check("reset_req", {63'd0, rr_req}, 64'd0);
    check("reset_gnt", {60'd0, rr_gnt}, 64'd0);
    check("reset_busy_err", {62'd0, rr_busy, rr_err}, 64'd0);
    check("reset_add", {32'd0, rr_add}, 64'd0);
    ch_req_i = 4'b0000;
    step(); step();
    rst_ni = 1'b1;
    mon_rr_en = 1'b1;

    // RR fairness: 4 grants then FIFO full.
    ch_req_i = 4'b1111; tcdm_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) exp_gnt(i);
    repeat (6) step();
    check("full_req_blocked", {63'd0, rr_req}, 64'd0);
    check("full_busy", {63'd0, rr_busy}, 64'd1);
    ch_req_i = 4'b0000; tcdm_r_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tcdm_r_data_i = rdata_of(k);
      exp_rv(k, rdata_of(k));
      step();
    end
    tcdm_r_valid_i = 1'b0;
    check("drain_busy", {63'd0, rr_busy}, 64'd0);

    // Write filtering: ch1 write then ch3 read.
    ch_wen_i = 4'b1101; ch_req_i = 4'b1010;
    exp_gnt(1); exp_gnt(3);
    step();
    ch_req_i = 4'b1000;
    step();
    ch_req_i = 4'b0000; tcdm_r_valid_i = 1'b1; tcdm_r_data_i = {9{32'hA5A5_A5A5}};
    step();
    exp_rv(3, {9{32'hA5A5_A5A5}});
    step();
    tcdm_r_valid_i = 1'b0; ch_wen_i = 4'b1111;

    // Backpressure on ch2.
    ch_req_i = 4'b0100; tcdm_gnt_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_gnt", {60'd0, rr_gnt}, 64'd0);
      check("bp_add", {31'd0, rr_req, rr_add}, {31'd0, 1'b1, addr_of(2)});
    end
    tcdm_gnt_i = 1'b1; exp_gnt(2);
    step();
    ch_req_i = 4'b1011; exp_gnt(3);
    step();
    ch_req_i = 4'b0000; tcdm_r_valid_i = 1'b1;
    tcdm_r_data_i = rdata_of(10); exp_rv(2, rdata_of(10)); step();
    tcdm_r_data_i = rdata_of(11); exp_rv(3, rdata_of(11)); step();
    tcdm_r_valid_i = 1'b0;

    // Full FIFO with simultaneous pop and new request.
    ch_req_i = 4'b1111;
    for (int i = 0; i < 4; i++) exp_gnt(i);
    repeat (4) step();
    tcdm_r_valid_i = 1'b1; tcdm_r_data_i = rdata_of(20); exp_rv(0, rdata_of(20));
    step();
    check("pushpop_busy", {63'd0, rr_busy}, 64'd1);
    tcdm_r_valid_i = 1'b0; exp_gnt(0);
    step();
    check("pushpop_busy2", {63'd0, rr_busy}, 64'd1);
    ch_req_i = 4'b0000; tcdm_r_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tcdm_r_data_i = rdata_of(21 + k);
      exp_rv((k + 1) % 4, rdata_of(21 + k));
      step();
    end
    tcdm_r_valid_i = 1'b0;
    check("pushpop_drain", {63'd0, rr_busy}, 64'd0);

    // Error: response with nothing outstanding, sticky until clear.
    check("err_before", {63'd0, rr_err}, 64'd0);
    tcdm_r_valid_i = 1'b1; step(); tcdm_r_valid_i = 1'b0;
    check("err_set", {63'd0, rr_err}, 64'd1);
    repeat (3) step();
    check("err_sticky", {63'd0, rr_err}, 64'd1);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    check("err_clear", {63'd0, rr_err}, 64'd0);

    // Fixed priority: ch0 wins over ch2 until it drops.
    mon_rr_en = 1'b0; mon_fp_en = 1'b1;
    ch_req_i = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      exp_fgnt_q.push_back(k < 6 ? 4'b0001 : 4'b0100);
      exp_fadd_q.push_back(k < 6 ? addr_of(0) : addr_of(2));
    end
    for (int k = 0; k < 8; k++) begin
      ch_req_i = (k < 6) ? 4'b0101 : 4'b0100;
      tcdm_r_valid_i = (k > 0);
      step();
    end
    ch_req_i = 4'b0000; tcdm_r_valid_i = 1'b1; step();
    tcdm_r_valid_i = 1'b0;
    mon_fp_en = 1'b0;
    check("fp_busy_end", {63'd0, fp_busy}, 64'd0);
    check("fp_queue_empty", 64'(exp_fgnt_q.size()), 64'd0);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    mon_rr_en = 1'b1;

    // Async reset mid-burst, first grant afterwards goes to ch0.
    ch_req_i = 4'b1111; tcdm_r_data_i = '0;
    exp_gnt(0); exp_gnt(1);
    step(); step();
    #2 rst_ni = 1'b0;
    #1;
    check("arst_req", {63'd0, rr_req}, 64'd0);
    check("arst_gnt", {60'd0, rr_gnt}, 64'd0);
    check("arst_busy_err", {62'd0, rr_busy, rr_err}, 64'd0);
    check("arst_rv_add", {28'd0, rr_rv, rr_add}, 64'd0);
    step();
    rst_ni = 1'b1; exp_gnt(0);
    step();
    ch_req_i = 4'b0000;
    step();
    check("post_rst_busy", {63'd0, rr_busy}, 64'd1);
    check("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'd0);
    check("rv_queue_empty", 64'(exp_rv_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
